// File: rtl/dispatch_queue_if.sv
// Decoder/dispatch side of the dispatch queue: push slots from decode,
// two-entry head window and occupancy towards dispatch.
interface dispatch_queue_if #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 128
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [1:0]             push_valid;
  logic [1:0][DATA_W-1:0] push_data;
  logic                   push_ready;
  logic [1:0]             pop_en;
  logic [1:0]             out_valid;
  logic [1:0][DATA_W-1:0] out_data;
  logic [PTR_W:0]         count;
  logic                   empty;
  logic                   full;

  modport master (
    output push_valid, push_data, pop_en,
    input  push_ready, out_valid, out_data, count, empty, full
  );

  modport slave (
    input  push_valid, push_data, pop_en,
    output push_ready, out_valid, out_data, count, empty, full
  );
endinterface

// File: rtl/dispatch_queue.sv
// In-order dual-push / dual-pop instruction buffer between decode and
// dual-issue dispatch; circular buffer with wrap-bit head/tail pointers.
module dispatch_queue #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 128,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic pause,
  dispatch_queue_if.slave q
);
  logic [DATA_W-1:0] mem [DEPTH];

  logic [PTR_W:0]    head_reg, head_next;
  logic [PTR_W:0]    tail_reg, tail_next;
  logic [PTR_W:0]    count;
  logic [PTR_W-1:0]  head_idx, head1_idx, tail_idx, tail1_idx;
  logic              do_push, pop0, pop1;
  logic [1:0]        n_push, n_pop;
  logic [DATA_W-1:0] wr0_data;

  assign count     = tail_reg - head_reg;
  assign head_idx  = head_reg[PTR_W-1:0];
  assign head1_idx = head_idx + 1'b1;
  assign tail_idx  = tail_reg[PTR_W-1:0];
  assign tail1_idx = tail_idx + 1'b1;

  assign q.count        = count;
  assign q.empty        = (count == '0);
  assign q.full         = (count == (PTR_W+1)'(DEPTH));
  // Ready looks only at registered occupancy, so no pop-to-ready path exists.
  assign q.push_ready   = (count <= (PTR_W+1)'(DEPTH - 2));
  assign q.out_valid[0] = (count != '0);
  assign q.out_valid[1] = (count >= (PTR_W+1)'(2));
  assign q.out_data[0]  = q.out_valid[0] ? mem[head_idx]  : '0;
  assign q.out_data[1]  = q.out_valid[1] ? mem[head1_idx] : '0;

  always_comb begin
    do_push   = 1'b0;
    n_push    = 2'd0;
    pop0      = 1'b0;
    pop1      = 1'b0;
    n_pop     = 2'd0;
    wr0_data  = q.push_data[0];
    head_next = head_reg;
    tail_next = tail_reg;

    do_push = q.push_ready && (q.push_valid != 2'b00);
    if (do_push)
      n_push = {1'b0, q.push_valid[0]} + {1'b0, q.push_valid[1]};
    // A lone slot1 entry is compacted into the tail position.
    wr0_data = q.push_valid[0] ? q.push_data[0] : q.push_data[1];

    // The illegal mask 10 degrades to a single pop.
    pop0  = !pause && (q.pop_en != 2'b00) && q.out_valid[0];
    pop1  = !pause && (q.pop_en == 2'b11) && q.out_valid[1];
    n_pop = {1'b0, pop0} + {1'b0, pop1};

    head_next = head_reg + (PTR_W+1)'(n_pop);
    tail_next = tail_reg + (PTR_W+1)'(n_push);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      head_reg <= head_next;
      tail_reg <= tail_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[tail_idx] <= wr0_data;
      if (q.push_valid == 2'b11)
        mem[tail1_idx] <= q.push_data[1];
    end
  end
endmodule
